// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-outstanding RAM port between the icache and dcache
//   requesters of NCORES cores. Cores are scanned round-robin starting at
//   rr_ptr; within a core dcache beats icache. A grant is registered in IDLE.
//   In GRANT the RAM is driven from the granted requester until the RAM reports
//   ACCESS (ack, one-cycle wait release) or the request drops (abort, no ack).
//
//   Optional feature macro: MEM_ARB_STARVE_GUARD_EN
//     When defined, each core counts consecutive dcache grants taken while its
//     icache is waiting. Once the count reaches STARVE_LIMIT, icache wins that
//     core's next selection. When undefined, dcache always beats icache.
//
// Ports
//   CLK, nRST             clock (rising edge), async active-low reset
//   iREN[c], iaddr[c]     icache read request/address per core
//   dREN/dWEN/daddr/dstore dcache request, address, write data per core
//   iwait/dwait           1 = access not complete, low for the ack cycle only
//   iload/dload           ramload broadcast to every lane
//   ramREN/ramWEN         RAM enables (write wins when both dcache bits set)
//   ramaddr/ramstore      RAM address/data, held in IDLE
//   ramload, ramstate     RAM read data and status (FREE/BUSY/ACCESS/ERROR)
module mem_arbiter #(
    parameter int NCORES       = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [NCORES-1:0]    iREN,
    input  logic [32*NCORES-1:0] iaddr,
    input  logic [NCORES-1:0]    dREN,
    input  logic [NCORES-1:0]    dWEN,
    input  logic [32*NCORES-1:0] daddr,
    input  logic [32*NCORES-1:0] dstore,
    output logic [NCORES-1:0]    iwait,
    output logic [NCORES-1:0]    dwait,
    output logic [32*NCORES-1:0] iload,
    output logic [32*NCORES-1:0] dload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [31:0]          ramaddr,
    output logic [31:0]          ramstore,
    input  logic [31:0]          ramload,
    input  logic [1:0]           ramstate
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_GRANT   = 1'b1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam int         CW         = (NCORES > 1) ? $clog2(NCORES) : 1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] gnt_core_q, gnt_core_d;
    logic          gnt_dc_q, gnt_dc_d;
    logic [31:0]   ramaddr_q, ramstore_q;

    logic [NCORES-1:0][31:0] iaddr_a, daddr_a, dstore_a;
    logic [NCORES-1:0]       dreq;
    logic [NCORES-1:0]       icache_first;

    logic          sel_found;
    logic [CW-1:0] sel_core;
    logic          sel_dc;
    logic [CW:0]   scan_sum;
    logic [CW-1:0] scan_idx;
    logic          gnt_live;

    assign iaddr_a  = iaddr;
    assign daddr_a  = daddr;
    assign dstore_a = dstore;
    assign dreq     = dREN | dWEN;
    assign iload    = {NCORES{ramload}};
    assign dload    = {NCORES{ramload}};

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [NCORES-1:0][SW-1:0] starve_q;
    logic                      idle_grant;

    assign idle_grant = (state_q == ST_IDLE) && sel_found;

    // Counts dcache grants taken while the same core's icache waits; any
    // icache grant or a dropped iREN restarts the count.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_q <= '0;
        end else begin
            for (int c = 0; c < NCORES; c++) begin
                if (!iREN[c]) begin
                    starve_q[c] <= '0;
                end else if (idle_grant && (sel_core == CW'(c))) begin
                    if (!sel_dc) begin
                        starve_q[c] <= '0;
                    end else if (starve_q[c] != SW'(STARVE_LIMIT)) begin
                        starve_q[c] <= starve_q[c] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        icache_first = '0;
        for (int c = 0; c < NCORES; c++) begin
            icache_first[c] = iREN[c] & (~dreq[c] | (starve_q[c] == SW'(STARVE_LIMIT)));
        end
    end
`else
    assign icache_first = iREN & ~dreq;

    // STARVE_LIMIT only matters to the starvation guard; nothing is built here.
    if (STARVE_LIMIT < 1) begin : g_unused_starve_limit
    end
`endif

    // Round-robin scan from rr_ptr; first core with any request wins.
    always_comb begin
        sel_found = 1'b0;
        sel_core  = '0;
        sel_dc    = 1'b0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < NCORES; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (CW+1)'(k);
            if (scan_sum >= (CW+1)'(NCORES)) begin
                scan_sum = scan_sum - (CW+1)'(NCORES);
            end
            scan_idx = scan_sum[CW-1:0];
            if (!sel_found && (dreq[scan_idx] || iREN[scan_idx])) begin
                sel_found = 1'b1;
                sel_core  = scan_idx;
                sel_dc    = ~icache_first[scan_idx];
            end
        end
    end

    assign gnt_live = gnt_dc_q ? dreq[gnt_core_q] : iREN[gnt_core_q];

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_core_d = gnt_core_q;
        gnt_dc_d   = gnt_dc_q;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = ramaddr_q;
        ramstore   = ramstore_q;
        iwait      = '1;
        dwait      = '1;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    gnt_core_d = sel_core;
                    gnt_dc_d   = sel_dc;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                ramaddr  = gnt_dc_q ? daddr_a[gnt_core_q] : iaddr_a[gnt_core_q];
                ramstore = dstore_a[gnt_core_q];
                if (!gnt_live) begin
                    // Requester withdrew: release the RAM without an ack.
                    state_d = ST_IDLE;
                end else begin
                    if (gnt_dc_q) begin
                        ramWEN = dWEN[gnt_core_q];
                        ramREN = ~dWEN[gnt_core_q];
                    end else begin
                        ramREN = 1'b1;
                    end
                    if (ramstate == RAM_ACCESS) begin
                        if (gnt_dc_q) begin
                            dwait[gnt_core_q] = 1'b0;
                        end else begin
                            iwait[gnt_core_q] = 1'b0;
                        end
                        rr_ptr_d = (gnt_core_q == CW'(NCORES - 1)) ? '0 : gnt_core_q + 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            gnt_core_q <= '0;
            gnt_dc_q   <= 1'b0;
            ramaddr_q  <= '0;
            ramstore_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_core_q <= gnt_core_d;
            gnt_dc_q   <= gnt_dc_d;
            ramaddr_q  <= ramaddr;
            ramstore_q <= ramstore;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int NC    = 2;
    localparam int LIMIT = 4;
    localparam logic [1:0] R_FREE   = 2'd0;
    localparam logic [1:0] R_BUSY   = 2'd1;
    localparam logic [1:0] R_ACCESS = 2'd2;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic                CLK = 1'b0;
    logic                nRST;
    logic [NC-1:0]       iREN, dREN, dWEN;
    logic [NC-1:0][31:0] iaddr, daddr, dstore;
    logic [NC-1:0]       iwait, dwait;
    logic [NC-1:0][31:0] iload, dload;
    logic                ramREN, ramWEN;
    logic [31:0]         ramaddr, ramstore, ramload;
    logic [1:0]          ramstate;

    mem_arbiter #(.NCORES(NC), .STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: who owns the RAM, where the next scan starts, starvation counts.
    bit          m_busy;
    int          m_core;
    bit          m_dc;
    int          m_rr;
    int          m_starve[NC];
    logic [31:0] m_addr, m_store;
    bit          ack_i[NC], ack_d[NC];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_core  = 0;
        m_dc    = 1'b0;
        m_rr    = 0;
        m_addr  = '0;
        m_store = '0;
        for (int c = 0; c < NC; c++) m_starve[c] = 0;
    endtask

    // Called just after a falling edge with this cycle's inputs applied:
    // compares outputs with the model, advances the model, waits a cycle.
    task automatic step();
        logic          e_ren, e_wen;
        logic [31:0]   e_addr, e_store;
        logic [NC-1:0] e_iw, e_dw;
        bit            live, got, g_i, dq;
        int            c, g_core;
        #1;
        for (int k = 0; k < NC; k++) begin ack_i[k] = 1'b0; ack_d[k] = 1'b0; end
        e_ren = 1'b0; e_wen = 1'b0; e_iw = '1; e_dw = '1;
        got = 1'b0; g_i = 1'b0; g_core = 0;
        if (!nRST) begin
            model_reset();
            e_addr = '0; e_store = '0;
        end else begin
            e_addr = m_addr; e_store = m_store;
            if (m_busy) begin
                c       = m_core;
                live    = m_dc ? (dREN[c] | dWEN[c]) : iREN[c];
                e_addr  = m_dc ? daddr[c] : iaddr[c];
                e_store = dstore[c];
                m_busy  = 1'b0;
                if (live) begin
                    if (m_dc) begin e_wen = dWEN[c]; e_ren = !dWEN[c]; end
                    else e_ren = 1'b1;
                    if (ramstate == R_ACCESS) begin
                        if (m_dc) begin e_dw[c] = 1'b0; ack_d[c] = 1'b1; end
                        else begin e_iw[c] = 1'b0; ack_i[c] = 1'b1; end
                        m_rr = (c + 1) % NC;
                    end else begin
                        m_busy = 1'b1;
                    end
                end
            end else begin
                for (int k = 0; k < NC; k++) begin
                    c  = (m_rr + k) % NC;
                    dq = dREN[c] | dWEN[c];
                    if (!got && (dq || iREN[c])) begin
                        got    = 1'b1;
                        g_core = c;
                        g_i    = iREN[c] && (!dq || (GUARD && m_starve[c] == LIMIT));
                        m_busy = 1'b1;
                        m_core = c;
                        m_dc   = !g_i;
                    end
                end
            end
            for (int k = 0; k < NC; k++) begin
                if (!iREN[k]) m_starve[k] = 0;
                else if (got && g_core == k) begin
                    if (g_i) m_starve[k] = 0;
                    else if (m_starve[k] < LIMIT) m_starve[k] = m_starve[k] + 1;
                end
            end
        end
        check("ramREN", ramREN, e_ren);
        check("ramWEN", ramWEN, e_wen);
        check("ramaddr", ramaddr, e_addr);
        check("ramstore", ramstore, e_store);
        check("iwait", iwait, e_iw);
        check("dwait", dwait, e_dw);
        check("iload", iload, {ramload, ramload});
        check("dload", dload, {ramload, ramload});
        m_addr  = e_addr;
        m_store = e_store;
        @(negedge CLK);
    endtask

    task automatic clear_reqs();
        iREN = '0; dREN = '0; dWEN = '0;
    endtask

    task automatic new_dreq(input int c);
        logic [1:0] op;
        op = 2'($urandom_range(1, 3));
        dREN[c]   = op[0];
        dWEN[c]   = op[1];
        daddr[c]  = $urandom;
        dstore[c] = $urandom;
    endtask

    task automatic drive_random();
        nRST = ($urandom_range(0, 299) != 0);
        for (int c = 0; c < NC; c++) begin
            if (!iREN[c]) begin
                if ($urandom_range(0, 2) == 0) begin iREN[c] = 1'b1; iaddr[c] = $urandom; end
            end else if (ack_i[c]) begin
                if ($urandom_range(0, 1) == 0) iREN[c] = 1'b0;
                else iaddr[c] = $urandom;
            end else if ($urandom_range(0, 39) == 0) begin
                iREN[c] = 1'b0;
            end
            if (!(dREN[c] | dWEN[c])) begin
                if ($urandom_range(0, 2) == 0) new_dreq(c);
            end else if (ack_d[c]) begin
                if ($urandom_range(0, 1) == 0) begin dREN[c] = 1'b0; dWEN[c] = 1'b0; end
                else new_dreq(c);
            end else if ($urandom_range(0, 39) == 0) begin
                dREN[c] = 1'b0; dWEN[c] = 1'b0;
            end
        end
        ramstate = 2'($urandom_range(0, 3));
        ramload  = $urandom;
    endtask

    int       order[$];
    logic [9:0] ipat;
    int       nack;

    initial begin
        nRST = 1'b0; clear_reqs();
        iaddr = '0; daddr = '0; dstore = '0;
        ramstate = R_FREE; ramload = 32'h1234_5678;
        model_reset();
        for (int k = 0; k < NC; k++) begin ack_i[k] = 1'b0; ack_d[k] = 1'b0; end
        @(negedge CLK);

        // Reset with a pending dcache read, then release.
        dREN[0] = 1'b1; daddr[0] = 32'h0000_1000;
        iREN[0] = 1'b1; iaddr[0] = 32'h0000_2000;
        #1;
        check("t1_rst_ramREN", ramREN, 1'b0);
        check("t1_rst_iwait", iwait, 2'b11);
        check("t1_rst_dwait", dwait, 2'b11);
        step();
        nRST = 1'b1; ramstate = R_BUSY;
        step();
        #1;
        check("t1_ramREN", ramREN, 1'b1);
        check("t1_ramaddr", ramaddr, 32'h0000_1000);
        step();
        step();
        // dcache beats icache; ACCESS after two BUSY cycles.
        ramstate = R_ACCESS;
        #1;
        check("t2_dack", dwait[0], 1'b0);
        check("t2_iwait_held", iwait[0], 1'b1);
        step();
        dREN[0] = 1'b0; ramstate = R_BUSY;
        #1;
        check("t2_dwait_one_cycle", dwait, 2'b11);
        step();
        #1;
        check("t2_icache_addr", ramaddr, 32'h0000_2000);
        check("t2_icache_ren", ramREN, 1'b1);
        ramstate = R_ACCESS;
        step();
        iREN[0] = 1'b0;

        // Round-robin from rr_ptr=0 with both dcaches held.
        nRST = 1'b0; step();
        nRST = 1'b1;
        dREN = 2'b11; daddr[0] = 32'hA000_0000; daddr[1] = 32'hA000_0001;
        ramstate = R_ACCESS;
        for (int cyc = 0; cyc < 20 && order.size() < 4; cyc++) begin
            #1;
            if (!dwait[0]) order.push_back(0);
            if (!dwait[1]) order.push_back(1);
            step();
        end
        check("t3_ack_count", 64'(order.size()), 64'd4);
        for (int k = 0; k < 4 && k < order.size(); k++)
            check("t3_rr_order", 64'(order[k]), 64'(k % 2));

        // Write wins over read.
        clear_reqs(); ramstate = R_FREE;
        step(); step();
        dWEN[1] = 1'b1; dREN[1] = 1'b1; dstore[1] = 32'hDEAD_BEEF; daddr[1] = 32'h0000_3000;
        ramstate = R_BUSY;
        step();
        #1;
        check("t4_ramWEN", ramWEN, 1'b1);
        check("t4_ramREN", ramREN, 1'b0);
        check("t4_ramstore", ramstore, 32'hDEAD_BEEF);
        ramstate = R_ACCESS;
        step();
        clear_reqs();

        // Abort keeps rr_ptr; reset mid-access clears outputs at once.
        dREN[0] = 1'b1; daddr[0] = 32'h0000_4000; ramstate = R_BUSY;
        step(); step();
        dREN[0] = 1'b0;
        #1;
        check("t5_abort_ren", ramREN, 1'b0);
        check("t5_abort_wen", ramWEN, 1'b0);
        check("t5_abort_dwait", dwait, 2'b11);
        step();
        dREN = 2'b11; daddr[1] = 32'h0000_5000;
        step();
        #1;
        check("t5_rr_kept", ramaddr, 32'h0000_4000);
        nRST = 1'b0;
        #1;
        check("t5_rst_ren", ramREN, 1'b0);
        check("t5_rst_addr", ramaddr, 32'h0);
        check("t5_rst_store", ramstore, 32'h0);
        check("t5_rst_dwait", dwait, 2'b11);
        step();
        nRST = 1'b1; clear_reqs();
        step();

        // Starvation: icache 0 and dcache 0 held, RAM always ready.
        iREN[0] = 1'b1; dREN[0] = 1'b1; iaddr[0] = 32'h0000_6000; daddr[0] = 32'h0000_7000;
        ramstate = R_ACCESS;
        ipat = '0; nack = 0;
        for (int cyc = 0; cyc < 60 && nack < 10; cyc++) begin
            #1;
            if (!dwait[0]) nack++;
            if (!iwait[0]) begin ipat[nack] = 1'b1; nack++; end
            step();
        end
        check("t6_ack_count", 64'(nack), 64'd10);
        check("t6_icache_pattern", ipat, GUARD ? 10'b10_0001_0000 : 10'b0);
        clear_reqs();
        step();

        // Randomised traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive_random();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
